// File: rtl/id_ex_register.sv
// ---------------------------------------------------------------------------
// id_ex_register
//
// Pipeline register between decode (ID) and execute (EX) of the 5-stage RV64
// core. Captures the two register-file operands plus the decoded instruction
// fields and presents them to EX one cycle later. Every output is driven
// directly by a flop.
//
// Register-file hazard: the register file writes on the same rising edge on
// which this stage samples ReadData1/ReadData2. The value being written
// therefore is not yet visible on the read ports, so a matching writeback is
// forwarded into the captured operand here. While stalled, the held operands
// are refreshed by matching writebacks so they never go stale.
//
// Valid semantics: in_valid marks a real instruction in decode; out_valid marks
// a real instruction in execute. There is no ready path; back-pressure comes
// only from the hazard unit through stall (hold) and flush (bubble), with
// priority flush > stall > load.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset clearing all state
//   in_valid          decode holds a valid instruction
//   in_pc, in_imm     PC and sign-extended immediate (XLEN)
//   in_rs1/rs2/rd     register indices (5 bits)
//   in_ctrl           opaque decoded control bundle (CTRL_W)
//   ReadData1/2       register-file read data for in_rs1/in_rs2
//   wb_RegWrite       writeback enable (same net as register file RegWrite)
//   wb_rd             writeback destination
//   wb_WriteData      writeback data
//   stall             hold contents this cycle
//   flush             replace contents with a bubble
//   out_*             registered copies of the fields above
//   out_op1/out_op2   resolved operands
// ---------------------------------------------------------------------------
module id_ex_register #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [XLEN-1:0]   ReadData1,
    input  logic [XLEN-1:0]   ReadData2,
    input  logic              wb_RegWrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_WriteData,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [CTRL_W-1:0] r_ctrl;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;

    // A write to x0 is architecturally discarded, so it never forwards.
    logic w_wb_live;
    assign w_wb_live = wb_RegWrite && (wb_rd != 5'd0);

    // Operand resolution for the load path: x0 reads as zero, otherwise a
    // same-edge writeback to the source wins over the (stale) read port.
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    always_comb begin
        w_op1 = ReadData1;
        if (in_rs1 == 5'd0) begin
            w_op1 = '0;
        end else if (w_wb_live && (wb_rd == in_rs1)) begin
            w_op1 = wb_WriteData;
        end
    end

    always_comb begin
        w_op2 = ReadData2;
        if (in_rs2 == 5'd0) begin
            w_op2 = '0;
        end else if (w_wb_live && (wb_rd == in_rs2)) begin
            w_op2 = wb_WriteData;
        end
    end

    // Refresh of held operands during a stall; applies even to a bubble so
    // the operand registers always mirror the current register-file value.
    logic w_refresh1;
    logic w_refresh2;
    assign w_refresh1 = w_wb_live && (wb_rd == r_rs1);
    assign w_refresh2 = w_wb_live && (wb_rd == r_rs2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_imm   <= '0;
            r_rs1   <= 5'd0;
            r_rs2   <= 5'd0;
            r_rd    <= 5'd0;
            r_ctrl  <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
        end else if (flush) begin
            // Bubble: kill the instruction, keep the datapath fields.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rd    <= 5'd0;
        end else if (stall) begin
            if (w_refresh1) begin
                r_op1 <= wb_WriteData;
            end
            if (w_refresh2) begin
                r_op2 <= wb_WriteData;
            end
        end else begin
            r_valid <= in_valid;
            r_pc    <= in_pc;
            r_imm   <= in_imm;
            r_rs1   <= in_rs1;
            r_rs2   <= in_rs2;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            // An invalid decode slot loads as a bubble: no side effects.
            r_rd    <= in_valid ? in_rd   : 5'd0;
            r_ctrl  <= in_valid ? in_ctrl : '0;
        end
    end

    assign out_valid = r_valid;
    assign out_pc    = r_pc;
    assign out_imm   = r_imm;
    assign out_rs1   = r_rs1;
    assign out_rs2   = r_rs2;
    assign out_rd    = r_rd;
    assign out_ctrl  = r_ctrl;
    assign out_op1   = r_op1;
    assign out_op2   = r_op2;

endmodule

// File: tb/tb_id_ex_register.sv
module tb_id_ex_register;

    localparam int XLEN   = 64;
    localparam int CTRL_W = 8;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [XLEN-1:0]   in_pc;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [4:0]        in_rd;
    logic [XLEN-1:0]   in_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic [XLEN-1:0]   ReadData1;
    logic [XLEN-1:0]   ReadData2;
    logic              wb_RegWrite;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_WriteData;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_imm;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [4:0]        out_rd;
    logic [CTRL_W-1:0] out_ctrl;
    logic [XLEN-1:0]   out_op1;
    logic [XLEN-1:0]   out_op2;

    int total;
    int bad;

    id_ex_register #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .in_imm       (in_imm),
        .in_ctrl      (in_ctrl),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .wb_RegWrite  (wb_RegWrite),
        .wb_rd        (wb_rd),
        .wb_WriteData (wb_WriteData),
        .stall        (stall),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_imm      (out_imm),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_ctrl     (out_ctrl),
        .out_op1      (out_op1),
        .out_op2      (out_op2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, XLEN'(out_valid), '0);
        chk({tag, "_pc"},    out_pc,           '0);
        chk({tag, "_imm"},   out_imm,          '0);
        chk({tag, "_rs1"},   XLEN'(out_rs1),   '0);
        chk({tag, "_rs2"},   XLEN'(out_rs2),   '0);
        chk({tag, "_rd"},    XLEN'(out_rd),    '0);
        chk({tag, "_ctrl"},  XLEN'(out_ctrl),  '0);
        chk({tag, "_op1"},   out_op1,          '0);
        chk({tag, "_op2"},   out_op2,          '0);
    endtask

    // Driver: present one decode-stage instruction.
    task automatic drive_id(input logic v, input logic [XLEN-1:0] pc,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [XLEN-1:0] imm,
                            input logic [CTRL_W-1:0] ctrl,
                            input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2);
        in_valid  = v;
        in_pc     = pc;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_imm    = imm;
        in_ctrl   = ctrl;
        ReadData1 = rd1;
        ReadData2 = rd2;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] rd,
                            input logic [XLEN-1:0] data);
        wb_RegWrite  = en;
        wb_rd        = rd;
        wb_WriteData = data;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive_id(1'b0, '0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0);
        drive_wb(1'b0, 5'd0, '0);

        // Reset state (clock running, reset held)
        tick();
        tick();
        chk_all_zero("reset");

        // First load after reset release: plain read-port data
        reset = 1'b1;
        drive_id(1'b1, 64'h100, 5'd5, 5'd6, 5'd10, 64'h20, 8'h3C,
                 64'h1234, 64'h5678);
        tick();
        chk("load_valid", XLEN'(out_valid), 64'd1);
        chk("load_op1",   out_op1, 64'h1234);
        chk("load_op2",   out_op2, 64'h5678);
        chk("load_pc",    out_pc,  64'h100);
        chk("load_imm",   out_imm, 64'h20);
        chk("load_rd",    XLEN'(out_rd),   64'd10);
        chk("load_ctrl",  XLEN'(out_ctrl), 64'h3C);
        chk("load_rs1",   XLEN'(out_rs1),  64'd5);

        // Asynchronous reset between edges clears everything immediately
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        reset = 1'b1;
        #1;

        // Same-edge forward to both operands from one writeback
        drive_id(1'b1, 64'h104, 5'd7, 5'd7, 5'd1, 64'h4, 8'h01,
                 64'h8, 64'h8);
        drive_wb(1'b1, 5'd7, 64'hDEAD);
        tick();
        chk("fwd_op1", out_op1, 64'hDEAD);
        chk("fwd_op2", out_op2, 64'hDEAD);

        // x0 reads as zero; write to x0 does not forward
        drive_id(1'b1, 64'h108, 5'd0, 5'd4, 5'd2, 64'h8, 8'h02,
                 64'h1, 64'h44);
        drive_wb(1'b1, 5'd0, 64'hFF);
        tick();
        chk("x0_op1", out_op1, 64'h0);
        chk("x0_op2", out_op2, 64'h44);

        // Writeback to a different register does not forward
        drive_id(1'b1, 64'h10C, 5'd8, 5'd9, 5'd3, 64'hC, 8'h03,
                 64'h88, 64'h99);
        drive_wb(1'b1, 5'd9, 64'h77);
        tick();
        chk("nofwd_op1", out_op1, 64'h88);
        chk("fwd2_op2",  out_op2, 64'h77);

        // Stall with refresh of a held operand
        drive_id(1'b1, 64'h200, 5'd2, 5'd3, 5'd11, 64'h30, 8'h11,
                 64'h20, 64'h10);
        drive_wb(1'b0, 5'd0, '0);
        tick();
        chk("pre_stall_op2", out_op2, 64'h10);
        stall = 1'b1;
        drive_id(1'b1, 64'h999, 5'd3, 5'd3, 5'd13, 64'h99, 8'hEE,
                 64'hBAD, 64'hBAD);
        tick();
        chk("stall1_op2", out_op2, 64'h10);
        chk("stall1_pc",  out_pc,  64'h200);
        drive_wb(1'b1, 5'd3, 64'h55);
        tick();
        chk("stall2_op2", out_op2, 64'h55);
        chk("stall2_op1", out_op1, 64'h20);
        drive_wb(1'b0, 5'd0, '0);
        tick();
        chk("stall3_op2",   out_op2, 64'h55);
        chk("stall3_pc",    out_pc,  64'h200);
        chk("stall3_imm",   out_imm, 64'h30);
        chk("stall3_rd",    XLEN'(out_rd),    64'd11);
        chk("stall3_ctrl",  XLEN'(out_ctrl),  64'h11);
        chk("stall3_valid", XLEN'(out_valid), 64'd1);
        chk("stall3_rs1",   XLEN'(out_rs1),   64'd2);

        // Stall released: the instruction advances
        stall = 1'b0;
        drive_id(1'b1, 64'h300, 5'd1, 5'd2, 5'd12, 64'h40, 8'hA5,
                 64'hAA, 64'hBB);
        tick();
        chk("adv_ctrl",  XLEN'(out_ctrl),  64'hA5);
        chk("adv_valid", XLEN'(out_valid), 64'd1);
        chk("adv_pc",    out_pc, 64'h300);

        // Flush wins over a simultaneous stall
        flush = 1'b1;
        stall = 1'b1;
        drive_id(1'b1, 64'h400, 5'd4, 5'd5, 5'd14, 64'h50, 8'h5A,
                 64'hCC, 64'hDD);
        tick();
        chk("flush_valid", XLEN'(out_valid), 64'd0);
        chk("flush_ctrl",  XLEN'(out_ctrl),  64'd0);
        chk("flush_rd",    XLEN'(out_rd),    64'd0);
        chk("flush_pc",    out_pc,  64'h300);
        chk("flush_op1",   out_op1, 64'hAA);

        // Bubble load: invalid slot zeroes ctrl/rd, other fields still load
        flush = 1'b0;
        stall = 1'b0;
        drive_id(1'b0, 64'h500, 5'd6, 5'd7, 5'd9, 64'h60, 8'hFF,
                 64'h66, 64'h67);
        tick();
        chk("bubble_valid", XLEN'(out_valid), 64'd0);
        chk("bubble_ctrl",  XLEN'(out_ctrl),  64'd0);
        chk("bubble_rd",    XLEN'(out_rd),    64'd0);
        chk("bubble_pc",    out_pc,  64'h500);
        chk("bubble_op1",   out_op1, 64'h66);

        // Report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

- Pipeline register between decode and execute in the 5-stage RV64 core.
- Captures the two operands read combinationally from `registerFile`, plus the decoded instruction fields, and presents them to the execute stage one cycle later.
- Resolves the same-cycle write/read hazard: the register file writes on the clock edge while this stage samples on that same edge.
- Supports stall (hold) and flush (bubble) from the hazard unit, keeps held operands coherent with writebacks that land during a stall, and forces x0 reads to zero.

## Interface
Parameters:
- `XLEN`, 64, operand/immediate/PC width
- `CTRL_W`, 8, width of the opaque decoded control bundle

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately
- `in_valid`  in  1  decode stage holds a valid instruction
- `in_pc`  in  XLEN  instruction PC
- `in_rs1`, `in_rs2`, `in_rd`  in  5 each  register indices
- `in_imm`  in  XLEN  sign-extended immediate
- `in_ctrl`  in  CTRL_W  decoded control bits
- `ReadData1`, `ReadData2`  in  XLEN  register file read ports for `in_rs1`/`in_rs2`
- `wb_RegWrite`  in  1  writeback enable, the same net as the register file's `RegWrite`
- `wb_rd`  in  5  writeback destination
- `wb_WriteData`  in  XLEN  writeback data
- `stall`  in  1  hold contents this cycle
- `flush`  in  1  replace contents with a bubble
- `out_valid`  out  1  execute stage holds a valid instruction
- `out_pc`, `out_imm`  out  XLEN each  registered copies
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  registered copies
- `out_ctrl`  out  CTRL_W  registered control; all-zero for a bubble
- `out_op1`, `out_op2`  out  XLEN each  resolved operands

## Operation
- All outputs come directly from flops; no combinational input-to-output paths.
- Resolution function, with n = 1 or 2:
  - opN = 0 if `in_rsN` == 0
  - otherwise `wb_WriteData` if `wb_RegWrite`=1 and `wb_rd`=`in_rsN`
  - otherwise `ReadDataN`
- Per-edge priority is flush > stall > load:
  - **Flush:** `out_valid`<=0, `out_ctrl`<=0, `out_rd`<=0; all other outputs hold. Flush wins over a simultaneous stall.
  - **Stall (no flush):** all fields hold, except operand refresh: if `wb_RegWrite`=1, `wb_rd`!=0 and `wb_rd`=`out_rsN`, then `out_opN`<=`wb_WriteData`. Refresh applies regardless of `out_valid`.
  - **Load (neither):** all `out_*`<=`in_*`, and `out_opN`<=resolved opN. If `in_valid`=0, then `out_ctrl`<=0 and `out_rd`<=0 (bubble). The other fields still load.
- Writes to x0 never forward. A `wb_rd`=0 write is ignored for both resolution and refresh.
- Both operands resolve independently. `in_rs1`=`in_rs2` with a matching writeback forwards to both.

## Timing
- Reset (`reset`=0, asynchronous): every output is 0, including `out_valid`, `out_ctrl` and all operands.
- Reset deassertion is synchronised externally. The first edge with `reset`=1 performs a normal load/stall/flush.
- Reset mid-stall or mid-flush discards held contents immediately, without waiting for a clock edge.
- Latency: exactly 1 cycle from decode inputs to `out_*`. Throughput is 1 instruction per cycle when not stalled.
- Stall of N cycles holds `out_*` for N edges. The instruction advances on the first edge with `stall`=0.
- Writeback forwarding covers only the same-edge case. Writes on earlier edges are already visible through `ReadDataN`.

## Test plan
- Reset/bypass:
  - `reset`=0 mid-run with `out_valid`=1 → all outputs 0 before the next edge.
  - Release reset, load `in_rs1`=5, `ReadData1`=0x1234, no writeback → `out_op1`=0x1234, `out_valid`=1 one cycle later.
- Same-edge forward: `in_rs1`=7, `in_rs2`=7, `ReadData1`=`ReadData2`=0x8, `wb_RegWrite`=1, `wb_rd`=7, `wb_WriteData`=0xDEAD → `out_op1`=`out_op2`=0xDEAD.
- x0: `in_rs1`=0, `ReadData1`=0x1, `wb_RegWrite`=1, `wb_rd`=0, `wb_WriteData`=0xFF → `out_op1`=0.
- Stall refresh: load `in_rs2`=3 (`out_op2`=0x10), then `stall`=1 for 3 cycles with writeback rd=3 data 0x55 on cycle 2 → `out_op2`=0x55 after cycle 2, all other outputs unchanged.
- Flush priority: `out_valid`=1, `out_ctrl`=0xA5; assert `flush`=1 and `stall`=1 together → next cycle `out_valid`=0, `out_ctrl`=0, `out_rd`=0, `out_pc` unchanged.
- Bubble load: `in_valid`=0, `in_ctrl`=0xFF, `in_rd`=9 → `out_valid`=0, `out_ctrl`=0, `out_rd`=0.
